mem_arbiter: RTL and testbench



---
 rtl/riscv_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared types and constants for the RV32I memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory port between fetch and data requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] MAX_STREAK = 4'(DATA_MAX_STREAK);

  arb_state_t r_state;
  mem_cmd_t   r_cmd;
  logic [3:0] r_streak;
  logic       w_pick_d;
  logic       w_pick_i;

  // Data wins ties unless it has already taken MAX_STREAK grants past a waiting fetch.
  always_comb begin
    w_pick_d = 1'b0;
    w_pick_i = 1'b0;
    if (d_req && (!if_req || (r_streak != MAX_STREAK))) begin
      w_pick_d = 1'b1;
    end else if (if_req) begin
      w_pick_i = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_streak  <= 4'd0;
      m_req     <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state <= BUSY_D;
            d_gnt   <= 1'b1;
            m_req   <= 1'b1;
            r_cmd   <= '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
            if (!if_req) begin
              r_streak <= 4'd0;
            end else if (r_streak != 4'hF) begin
              r_streak <= r_streak + 4'd1;
            end
          end else if (w_pick_i) begin
            r_state  <= BUSY_I;
            if_gnt   <= 1'b1;
            m_req    <= 1'b1;
            r_cmd    <= '{we: 1'b0, addr: if_addr, wdata: 32'h0, be: BE_WORD};
            r_streak <= 4'd0;
          end
        end
        BUSY_I: begin
          if (m_ack) begin
            r_state   <= IDLE;
            m_req     <= 1'b0;
            if_rdata  <= m_rdata;
            if_rvalid <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            r_state  <= IDLE;
            m_req    <= 1'b0;
            d_rdata  <= m_rdata;
            d_rvalid <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          m_req   <= 1'b0;
        end
      endcase
    end
  end

  assign m_we    = r_cmd.we;
  assign m_addr  = r_cmd.addr;
  assign m_wdata = r_cmd.wdata;
  assign m_be    = r_cmd.be;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed scenarios plus randomized traffic vs a reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    n_cmp++; if ({m_req, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {m_req, if_gnt, d_gnt, if_rvalid, d_rvalid}); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
    n_cmp++; if ({m_we, m_addr, m_wdata, m_be} !== 69'h0) begin n_bad++; $display("FAIL reset_cmd: got %h want 0", {m_we, m_addr, m_wdata, m_be}); end
    n_cmp++; if (dut.r_streak !== 4'd0) begin n_bad++; $display("FAIL reset_streak: got %0d want 0", dut.r_streak); end
    rst = 1'b0;
    step();
    m_ack = 1'b1; m_rdata = 32'hFFFF_0000;
    step();
    m_ack = 1'b0;
    step();
    n_cmp++; if ({m_req, if_rvalid, d_rvalid, if_rdata, d_rdata} !== 67'h0) begin n_bad++; $display("FAIL idle_ack_ignored: got %h want 0", {m_req, if_rvalid, d_rvalid, if_rdata, d_rdata}); end
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    step();
    n_cmp++; if ({if_gnt, d_gnt, m_req} !== 3'b101) begin n_bad++; $display("FAIL fetch_gnt: got %b want 101", {if_gnt, d_gnt, m_req}); end
    n_cmp++; if ({m_we, m_addr, m_wdata, m_be} !== {1'b0, 32'h10, 32'h0, 4'hF}) begin n_bad++; $display("FAIL fetch_cmd: got %h want %h", {m_we, m_addr, m_wdata, m_be}, {1'b0, 32'h10, 32'h0, 4'hF}); end
    if_req = 1'b0;
    step();
    n_cmp++; if ({if_gnt, m_req} !== 2'b01) begin n_bad++; $display("FAIL fetch_c2: got %b want 01", {if_gnt, m_req}); end
    step();
    n_cmp++; if ({m_req, if_rvalid, m_addr} !== {2'b10, 32'h10}) begin n_bad++; $display("FAIL fetch_c3: got %h want %h", {m_req, if_rvalid, m_addr}, {2'b10, 32'h10}); end
    m_ack = 1'b1; m_rdata = 32'h0000_0513;
    step();
    m_ack = 1'b0;
    n_cmp++; if ({if_rvalid, d_rvalid, m_req, if_rdata} !== {3'b100, 32'h0000_0513}) begin n_bad++; $display("FAIL fetch_rvalid: got %h want %h", {if_rvalid, d_rvalid, m_req, if_rdata}, {3'b100, 32'h0000_0513}); end
    step();
    n_cmp++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h0000_0513}) begin n_bad++; $display("FAIL fetch_hold: got %h want %h", {if_rvalid, if_rdata}, {1'b0, 32'h0000_0513}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; d_wdata = 32'h0;
    step();
    n_cmp++; if ({d_gnt, if_gnt, m_addr, m_we} !== {2'b10, 32'h100, 1'b0}) begin n_bad++; $display("FAIL sim_dgnt: got %h want %h", {d_gnt, if_gnt, m_addr, m_we}, {2'b10, 32'h100, 1'b0}); end
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hDEAD_0001;
    step();
    m_ack = 1'b0;
    n_cmp++; if ({d_rvalid, if_gnt, m_req, d_rdata} !== {3'b100, 32'hDEAD_0001}) begin n_bad++; $display("FAIL sim_drvalid: got %h want %h", {d_rvalid, if_gnt, m_req, d_rdata}, {3'b100, 32'hDEAD_0001}); end
    step();
    n_cmp++; if ({if_gnt, d_gnt, m_addr, m_be} !== {2'b10, 32'h40, 4'hF}) begin n_bad++; $display("FAIL sim_ignt: got %h want %h", {if_gnt, d_gnt, m_addr, m_be}, {2'b10, 32'h40, 4'hF}); end
    if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0000_0093;
    step();
    m_ack = 1'b0;
    n_cmp++; if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h0000_0093}) begin n_bad++; $display("FAIL sim_irvalid: got %h want %h", {if_rvalid, d_rvalid, if_rdata}, {2'b10, 32'h0000_0093}); end
    step();
  endtask

  task automatic test_store();
    int if_act = 0;
    int rv_cnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE_BABE; d_be = 4'b0011;
    step();
    n_cmp++; if ({d_gnt, m_we, m_addr, m_wdata, m_be} !== {2'b11, 32'h200, 32'hCAFE_BABE, 4'b0011}) begin n_bad++; $display("FAIL store_cmd: got %h want %h", {d_gnt, m_we, m_addr, m_wdata, m_be}, {2'b11, 32'h200, 32'hCAFE_BABE, 4'b0011}); end
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; d_be = 4'h0;
    for (int c = 0; c < 5; c++) begin
      if (if_gnt || if_rvalid) if_act++;
      if (d_rvalid) rv_cnt++;
      if (c == 1) begin
        n_cmp++; if ({m_req, m_we, m_wdata, m_be} !== {2'b11, 32'hCAFE_BABE, 4'b0011}) begin n_bad++; $display("FAIL store_stable: got %h want %h", {m_req, m_we, m_wdata, m_be}, {2'b11, 32'hCAFE_BABE, 4'b0011}); end
      end
      m_ack = (c == 1); m_rdata = 32'h0000_1234;
      step();
    end
    m_ack = 1'b0;
    n_cmp++; if (rv_cnt !== 1) begin n_bad++; $display("FAIL store_rvalid_count: got %0d want 1", rv_cnt); end
    n_cmp++; if (d_rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL store_rdata: got %h want 00001234", d_rdata); end
    n_cmp++; if (if_act !== 0) begin n_bad++; $display("FAIL store_if_quiet: got %0d want 0", if_act); end
  endtask

  task automatic test_starvation();
    int order[$];
    int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int max_streak = 0;
    int both = 0;
    int got;
    do_reset();
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
    for (int c = 0; c < 60; c++) begin
      if (d_gnt) order.push_back(1);
      if (if_gnt) order.push_back(0);
      if (d_gnt && if_gnt) both++;
      if (int'(dut.r_streak) > max_streak) max_streak = int'(dut.r_streak);
      m_ack = m_req; m_rdata = 32'(c);
      if (order.size() >= 10) begin if_req = 1'b0; d_req = 1'b0; end
      step();
      if (order.size() >= 10) break;
    end
    m_ack = 1'b0;
    step();
    n_cmp++; if (order.size() !== 10) begin n_bad++; $display("FAIL starve_count: got %0d want 10", order.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < order.size()) ? order[i] : -1;
      n_cmp++; if (got !== exp_order[i]) begin n_bad++; $display("FAIL starve_order[%0d]: got %0d want %0d (1=D 0=I)", i, got, exp_order[i]); end
    end
    n_cmp++; if (max_streak !== MAX_STREAK) begin n_bad++; $display("FAIL starve_max_streak: got %0d want %0d", max_streak, MAX_STREAK); end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL starve_dual_gnt: got %0d want 0", both); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    step();
    n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL rmid_gnt: got %b want 1", d_gnt); end
    d_req = 1'b0;
    step();
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got %b want 1", m_req); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({m_req, d_gnt, d_rvalid, if_gnt, if_rvalid} !== 5'b0) begin n_bad++; $display("FAIL rmid_async: got %b want 00000", {m_req, d_gnt, d_rvalid, if_gnt, if_rvalid}); end
    step();
    rst = 1'b0;
    step();
    step();
    m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
    step();
    m_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if ({m_req, d_gnt, d_rvalid, if_gnt, if_rvalid, d_rdata} !== 37'h0) begin n_bad++; $display("FAIL rmid_late_ack[%0d]: got %h want 0", c, {m_req, d_gnt, d_rvalid, if_gnt, if_rvalid, d_rdata}); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int gnt_cyc[$];
    logic [31:0] a = 32'h1000;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = 4'hF;
    for (int c = 0; c < 14; c++) begin
      if (d_gnt) begin
        gnt_cyc.push_back(c);
        n_cmp++; if (m_addr !== d_addr) begin n_bad++; $display("FAIL b2b_addr: got %h want %h", m_addr, d_addr); end
        d_req = 1'b0;
      end
      if (d_rvalid) begin
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_mreq: got %b want 0", m_req); end
        a = a + 32'd4;
        if (c < 12) begin d_req = 1'b1; d_addr = a; end
      end
      m_ack = m_req; m_rdata = a;
      step();
    end
    for (int c = 0; c < 3; c++) begin m_ack = m_req; step(); end
    m_ack = 1'b0;
    n_cmp++; if (gnt_cyc.size() !== 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", gnt_cyc.size()); end
    for (int i = 0; i < gnt_cyc.size(); i++) begin
      n_cmp++; if (gnt_cyc[i] !== 1 + 2 * i) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got cycle %0d want %0d", i, gnt_cyc[i], 1 + 2 * i); end
    end
  endtask

  // Reference: one transaction at a time, arbitration decided only when free.
  task automatic test_random();
    bit          free = 1'b1;
    bit          owner_d = 1'b0;
    int          run = 0;
    int          wait_c = 0;
    mem_cmd_t    cmd = '0;
    bit          e_ig = 1'b0, e_dg = 1'b0, e_ir = 1'b0, e_dr = 1'b0;
    logic [31:0] e_ird = 32'h0, e_drd = 32'h0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== {e_ig, e_dg, e_ir, e_dr}) begin n_bad++; $display("FAIL rnd_pulses c%0d: got %b want %b", c, {if_gnt, d_gnt, if_rvalid, d_rvalid}, {e_ig, e_dg, e_ir, e_dr}); end
      n_cmp++; if (m_req !== !free) begin n_bad++; $display("FAIL rnd_mreq c%0d: got %b want %b", c, m_req, !free); end
      if (!free) begin
        n_cmp++; if ({m_we, m_addr, m_wdata, m_be} !== cmd) begin n_bad++; $display("FAIL rnd_cmd c%0d: got %h want %h", c, {m_we, m_addr, m_wdata, m_be}, cmd); end
      end
      n_cmp++; if ({if_rdata, d_rdata} !== {e_ird, e_drd}) begin n_bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, {if_rdata, d_rdata}, {e_ird, e_drd}); end

      if (if_gnt) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFFC; end
      if (d_gnt) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom()); d_addr = $urandom(); d_wdata = $urandom(); d_be = 4'($urandom());
      end
      if (!free) begin
        if (wait_c == 0) m_ack = 1'b1; else begin m_ack = 1'b0; wait_c--; end
      end else begin
        m_ack = ($urandom_range(0, 3) == 0);
      end
      m_rdata = $urandom();

      e_ig = 1'b0; e_dg = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
      if (free) begin
        wait_c = $urandom_range(0, 3);
        if (d_req && (!if_req || run != MAX_STREAK)) begin
          e_dg = 1'b1; free = 1'b0; owner_d = 1'b1;
          cmd = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
          run = if_req ? ((run < 15) ? run + 1 : 15) : 0;
        end else if (if_req) begin
          e_ig = 1'b1; free = 1'b0; owner_d = 1'b0;
          cmd = '{we: 1'b0, addr: if_addr, wdata: 32'h0, be: 4'hF};
          run = 0;
        end
      end else if (m_ack) begin
        free = 1'b1;
        if (owner_d) begin e_dr = 1'b1; e_drd = m_rdata; end
        else begin e_ir = 1'b1; e_ird = m_rdata; end
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 10; c++) begin m_ack = m_req; step(); end
    m_ack = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_store();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
